// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard / stall controller for a 5-stage MIPS-style core.
//   Detects load-use hazards, branch operand hazards (branch resolves in ID)
//   and multiply/divide result hazards, and drives the PC / IF-ID write
//   enables and the bubble/flush controls.
//
// Parameters
//   MDU_LAT        multiply/divide latency in cycles (legal 2..63)
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   IFID_*         source regs and class of the instruction in ID
//   IDEX_*         EX destination / write / load flags
//   EXMEM_*        MEM destination / load flag
//   Branch_Taken   branch decision from ID
//   MDU_Start      mult/div entering EX this cycle
//   PC_Wr, IFID_Wr write enables (0 = stall)
//   IFID_Flush     squash the fetched instruction (taken branch)
//   IDEX_Flush     insert a bubble into EX (stall)
//   MDU_Busy       MDU result pending
//   Stall_Cnt      saturating stall-cycle counter, only when the macro
//                  HAZARD_PERF_CNT_EN is defined
module hazard_stall_ctrl #(
  parameter int MDU_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IFID_UseRt,
  input  logic       IFID_Branch,
  input  logic       IFID_MduUse,
  input  logic [4:0] IDEX_Rd,
  input  logic       IDEX_RegWr,
  input  logic       IDEX_MemRd,
  input  logic [4:0] EXMEM_Rd,
  input  logic       EXMEM_MemRd,
  input  logic       Branch_Taken,
  input  logic       MDU_Start,
  output logic       PC_Wr,
  output logic       IFID_Wr,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       MDU_Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] Stall_Cnt
`endif
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [5:0] LAT_M1 = 6'(MDU_LAT - 1);

  state_t     state, state_nxt;
  logic [5:0] mdu_cnt, mdu_cnt_nxt;

  // Register zero is never a real dependency; Rt only counts when read.
  function automatic logic hit(input logic [4:0] dst, input logic [4:0] rs,
                               input logic [4:0] rt, input logic use_rt);
    return (dst != 5'd0) && ((dst == rs) || (use_rt && (dst == rt)));
  endfunction

  logic load_use, br_stall, mdu_stall, stall;

  always_comb begin
    load_use  = IDEX_MemRd && hit(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UseRt);
    br_stall  = IFID_Branch &&
                ((IDEX_RegWr  && hit(IDEX_Rd,  IFID_Rs, IFID_Rt, IFID_UseRt)) ||
                 (EXMEM_MemRd && hit(EXMEM_Rd, IFID_Rs, IFID_Rt, IFID_UseRt)));
    // Only state feeds this term, so MDU_Start never reaches an output.
    mdu_stall = (state == MDU_WAIT) && IFID_MduUse;
    stall     = load_use || br_stall || mdu_stall;
  end

  // Outputs: reset forces a full freeze+flush; stall beats a taken branch.
  always_comb begin
    PC_Wr      = !stall;
    IFID_Wr    = !stall;
    IFID_Flush = !stall && Branch_Taken;
    IDEX_Flush = stall;
    MDU_Busy   = (state == MDU_WAIT);
    if (rst) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
      MDU_Busy   = 1'b0;
    end
  end

  // MDU wait FSM: busy for MDU_LAT-1 cycles after the start edge.
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    case (state)
      RUN: begin
        if (MDU_Start) begin
          state_nxt   = MDU_WAIT;
          mdu_cnt_nxt = LAT_M1;
        end
      end
      MDU_WAIT: begin
        if (MDU_Start) begin
          mdu_cnt_nxt = LAT_M1;        // restart wins over the countdown
        end else begin
          mdu_cnt_nxt = mdu_cnt - 6'd1;
          if (mdu_cnt == 6'd1) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt   = RUN;
        mdu_cnt_nxt = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mdu_cnt <= 6'd0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      Stall_Cnt <= 16'd0;
    else if (stall && (Stall_Cnt != 16'hFFFF))
      Stall_Cnt <= Stall_Cnt + 16'd1;
  end
`endif

endmodule
